instr_encoder: RTL
==================

Name: instr_encoder

Overview:
- Inverse of the immgen decoder. Packs decoded fields (format, registers, funct3, 32-bit immediate) into a 32-bit RV32I instruction word for LOAD, OP-IMM, STORE, BRANCH and JAL.
- Used by the self-test/boot loader to write instruction memory. Emits one instruction per handshake, tags it with a sequential word address, and flags immediates that do not fit their format.

Parameters:
- CNT_W, 16, width of the emitted-instruction counter.
- NOP_WORD, 32'h0000_0013, word substituted on an encode error (addi x0,x0,0).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  synchronous active-low reset.
- start_i  in  1  load base address and clear counter.
- base_addr_i  in  32  base byte address; bits [1:0] ignored (forced 0).
- in_valid_i  in  1  input fields valid.
- in_ready_o  out  1  encoder can accept.
- fmt_i  in  3  0 LOAD, 1 OPIMM, 2 STORE, 3 BRANCH, 4 JAL; 5-7 illegal.
- rd_i  in  5  destination register.
- rs1_i  in  5  source register 1.
- rs2_i  in  5  source register 2.
- funct3_i  in  3  funct3 field.
- imm_i  in  32  signed immediate (byte offset for BRANCH/JAL).
- out_valid_o  out  1  output beat valid.
- out_ready_i  in  1  consumer accepts beat.
- instr_o  out  32  encoded instruction.
- addr_o  out  32  byte address of instr_o.
- err_o  out  1  beat carries an encode error.
- count_o  out  CNT_W  beats accepted by consumer, saturating.

Behaviour:
- Reset (rst_ni=0 at clk edge): out_valid_o=0, instr_o=0, addr_o=0, err_o=0, count_o=0, internal address pointer=0. Reset has priority over every other input. Mid-operation reset drops a held beat with no output.
- Handshake: input accepted when in_valid_i & in_ready_o. Output transfers when out_valid_o & out_ready_i.
- in_ready_o = !out_valid_o | out_ready_i, combinational. This is a one-entry register stage with no bubble under continuous ready.
- Latency: a beat accepted at edge N is valid on out_valid_o after edge N. instr_o, addr_o and err_o are stable while out_valid_o=1 and out_ready_i=0.
- out_valid_o sets on accept. It clears on an output transfer with no simultaneous accept. On simultaneous transfer and accept it stays 1 with the new beat.
- Encoding:
  - LOAD: {imm[11:0], rs1, funct3, rd, 7'b0000011}.
  - OPIMM: same layout, opcode 7'b0010011.
  - STORE: {imm[11:5], rs2, rs1, funct3, imm[4:0], 7'b0100011}.
  - BRANCH: {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], 7'b1100011}.
  - JAL: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}. rs1, rs2 and funct3 are ignored.
- Range checks (error if violated):
  - LOAD/OPIMM/STORE: imm[31:11] all equal.
  - BRANCH: imm[31:12] all equal and imm[0]=0.
  - JAL: imm[31:20] all equal and imm[0]=0.
  - fmt_i 5-7: always an error.
- On error: beat still emitted with instr_o=NOP_WORD and err_o=1. The address still advances.
- Address: each accepted beat takes addr_o = pointer, then pointer += 4, wrapping mod 2^32 (0xFFFF_FFFC -> 0).
- start_i:
  - Loads pointer = {base_addr_i[31:2], 2'b00} and clears count_o.
  - If start_i and an accept occur in the same cycle, the accepted beat takes the new base and the pointer becomes base+4.
  - A beat already held in the output register keeps its address.
- count_o: increments on each output transfer and saturates at all-ones. start_i clearing wins over a simultaneous increment.
- Round-trip property: for every legal beat, passing instr_o through immgen returns imm_i.

Test Plan:
- Reset, start_i with base 0x100, OPIMM rd=1 rs1=0 f3=0 imm=5, out_ready_i=1 -> next cycle instr_o=0x00500093, addr_o=0x100, err_o=0, count_o=1 after transfer.
- Back-to-back STORE rs1=1 rs2=2 f3=2 imm=8, then BRANCH rs1=1 rs2=2 f3=0 imm=-4, then JAL rd=1 imm=8, ready held 1 -> 0x0020A423 @0x100, 0xFE208EE3 @0x104, 0x008000EF @0x108, in_ready_o=1 throughout.
- Backpressure: out_ready_i=0 for 3 cycles with in_valid_i=1 -> in_ready_o=0, outputs stable, no beat lost. Release -> beats emitted in order, addresses consecutive.
- Errors:
  - OPIMM imm=2048 -> instr_o=0x00000013, err_o=1.
  - BRANCH imm=3 -> err_o=1.
  - fmt_i=6 -> err_o=1.
  - In all three cases addr_o still advances by 4.
- Base 0xFFFF_FFFC, two beats -> addr 0xFFFF_FFFC then 0x0000_0000. start_i coincident with accept uses the new base. rst_ni low with out_valid_o=1 -> out_valid_o=0, count_o=0 next edge.

Source files
------------

// File: rtl/instr_encoder.sv
// RV32I instruction encoder: packs decoded fields into LOAD/OP-IMM/STORE/BRANCH/JAL words
// through a one-entry valid/ready output register, tagging each beat with its word address.
module instr_encoder #(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [31:0]      base_addr_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [2:0]       fmt_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [2:0]       funct3_i,
  input  logic [31:0]      imm_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [31:0]      instr_o,
  output logic [31:0]      addr_o,
  output logic             err_o,
  output logic [CNT_W-1:0] count_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  logic             out_valid_q, out_valid_d;
  logic [31:0]      instr_q, instr_d;
  logic [31:0]      addr_q, addr_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      ptr_q, ptr_d;

  logic             accept, xfer;
  logic [31:0]      enc_word, raw_word, ptr_base;
  logic             enc_err;
  logic             unused_base_lsb;

  assign unused_base_lsb = ^base_addr_i[1:0];

  assign in_ready_o = !out_valid_q | out_ready_i;
  assign accept     = in_valid_i & in_ready_o;
  assign xfer       = out_valid_q & out_ready_i;

  always_comb begin
    raw_word = NOP_WORD;
    enc_err  = 1'b1;
    case (fmt_i)
      3'd0: begin
        raw_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_LOAD};
        enc_err  = (imm_i[31:11] != {21{imm_i[11]}});
      end
      3'd1: begin
        raw_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, OPC_OPIMM};
        enc_err  = (imm_i[31:11] != {21{imm_i[11]}});
      end
      3'd2: begin
        raw_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], OPC_STORE};
        enc_err  = (imm_i[31:11] != {21{imm_i[11]}});
      end
      3'd3: begin
        raw_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i, imm_i[4:1], imm_i[11],
                    OPC_BRANCH};
        enc_err  = (imm_i[31:12] != {20{imm_i[12]}}) | imm_i[0];
      end
      3'd4: begin
        raw_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, OPC_JAL};
        enc_err  = (imm_i[31:20] != {12{imm_i[20]}}) | imm_i[0];
      end
      default: begin
        raw_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
    enc_word = enc_err ? NOP_WORD : raw_word;
  end

  // A start coincident with an accept hands the new base to that same beat.
  always_comb begin
    ptr_base    = start_i ? {base_addr_i[31:2], 2'b00} : ptr_q;
    out_valid_d = out_valid_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    err_d       = err_q;
    ptr_d       = ptr_base;
    if (accept) begin
      out_valid_d = 1'b1;
      instr_d     = enc_word;
      err_d       = enc_err;
      addr_d      = ptr_base;
      ptr_d       = ptr_base + 32'd4;
    end else if (xfer) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    count_d = count_q;
    if (start_i) begin
      count_d = '0;
    end else if (xfer && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      out_valid_q <= 1'b0;
      instr_q     <= '0;
      addr_q      <= '0;
      err_q       <= 1'b0;
      count_q     <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
    end
  end

  assign out_valid_o = out_valid_q;
  assign instr_o     = instr_q;
  assign addr_o      = addr_q;
  assign err_o       = err_q;
  assign count_o     = count_q;

endmodule
